// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and
// the index-width helper used to size requester IDs.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Bits needed to index n requesters, never less than 1.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port as seen by the write arbiter.
// slave = arbiter side, master = requesters/FIFO environment side.
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr,
// in circular order over NUM_REQ entries.
module fifo_wr_arbiter_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic                o_any,
    output logic [ID_WIDTH-1:0] o_idx
);

    logic [ID_WIDTH:0] w_sum;

    // Scan farthest-to-nearest so the nearest hit is the last one written.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (ID_WIDTH + 1)'(k);
            if (w_sum >= (ID_WIDTH + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_WIDTH + 1)'(NUM_REQ);
            end
            if (i_req[w_sum[ID_WIDTH-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_sum[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one async-FIFO write port
// among NUM_REQ valid/ready/last streams in the wclk domain.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);

    state_t              r_state;
    logic [ID_WIDTH-1:0] r_owner;
    logic [ID_WIDTH-1:0] r_rr_ptr;

    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_pick;
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic                  w_xfer;
    logic                  w_winc;

    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] idx);
        return (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + ID_WIDTH'(1);
    endfunction

    fifo_wr_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // Owner's stream, selected by comparison so no index can exceed NUM_REQ-1.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == ID_WIDTH'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_last  = bus.req_last[i];
                w_own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer = (r_state == ST_XFER);
    assign w_winc = w_xfer & w_own_valid & ~bus.wfull;

    assign bus.winc      = w_winc;
    assign bus.wdata     = w_xfer ? w_own_data : '0;
    assign bus.busy      = w_xfer;
    assign bus.grant_id  = r_owner;
    assign bus.req_ready = {NUM_REQ{w_xfer & ~bus.wfull}} & (NUM_REQ'(1) << r_owner);

    // Grant is taken in IDLE and held until the owner's last word is written.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_XFER;
                        r_owner <= w_pick;
                    end
                end
                ST_XFER: begin
                    if (w_winc && w_own_last) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= next_ptr(r_owner);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester instance driven by a
// packet source model, plus a 3-requester instance for the wrap case.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_WIDTH(IW)) b4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(DW), .ID_WIDTH(IW)) b3 ();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut4 (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (b4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut3 (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (b3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Source model: word w of packet p from requester i carries i*64 + p*8 + w.
    logic [N-1:0]  en;
    int            len  [N];
    int            npkt [N];
    int            wcnt [N];
    int            pcnt [N];
    logic          wfull_drv;
    logic [DW-1:0] log_q [$];

    logic          s_winc;
    logic          s_busy;
    logic [N-1:0]  s_ready;
    logic [IW-1:0] s_gid;
    logic [DW-1:0] s_wdata;

    task automatic drive4();
        for (int i = 0; i < N; i++) begin
            b4.req_valid[i]           = en[i] && (pcnt[i] < npkt[i]);
            b4.req_last[i]            = (wcnt[i] == len[i] - 1);
            b4.req_data[i*DW +: DW]   = DW'(i*64 + pcnt[i]*8 + wcnt[i]);
        end
        b4.wfull = wfull_drv;
    endtask

    task automatic idle3();
        b3.req_valid = '0;
        b3.req_last  = '0;
        b3.req_data  = '0;
        b3.wfull     = 1'b0;
    endtask

    // One wclk cycle: drive, sample mid-cycle, log FIFO writes, advance sources.
    task automatic tick4();
        logic [N-1:0] fire;
        drive4();
        #2;
        s_winc  = b4.winc;
        s_ready = b4.req_ready;
        s_busy  = b4.busy;
        s_gid   = b4.grant_id;
        s_wdata = b4.wdata;
        fire    = b4.req_valid & b4.req_ready;
        if (s_winc) log_q.push_back(s_wdata);
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                wcnt[i]++;
                if (wcnt[i] == len[i]) begin
                    wcnt[i] = 0;
                    pcnt[i]++;
                end
            end
        end
    endtask

    task automatic do_reset(input logic [N-1:0] en_i);
        @(posedge wclk);
        #1;
        wrst_n    = 1'b0;
        en        = en_i;
        wfull_drv = 1'b0;
        for (int i = 0; i < N; i++) begin
            wcnt[i] = 0;
            pcnt[i] = 0;
        end
        log_q.delete();
        drive4();
        idle3();
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            len[i]  = 3;
            npkt[i] = 1;
            wcnt[i] = 0;
            pcnt[i] = 0;
        end
        en        = 4'b1111;
        wfull_drv = 1'b0;
        idle3();
        @(posedge wclk);
        #1;
        wrst_n = 1'b0;
        drive4();
        #2;
        n_chk++; if (b4.winc !== 1'b0) $display("FAIL rst_winc: got %b want 0", b4.winc); else n_pass++;
        n_chk++; if (b4.req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", b4.req_ready); else n_pass++;
        n_chk++; if (b4.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", b4.busy); else n_pass++;
        n_chk++; if (b4.grant_id !== 2'd0) $display("FAIL rst_gid: got %0d want 0", b4.grant_id); else n_pass++;
        n_chk++; if (b4.wdata !== 8'h00) $display("FAIL rst_wdata: got %0h want 0", b4.wdata); else n_pass++;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        log_q.delete();
        tick4();
        n_chk++; if ({s_busy, s_winc} !== 2'b00) $display("FAIL rst_arb_cycle: got busy/winc %b want 00", {s_busy, s_winc}); else n_pass++;
        tick4();
        n_chk++; if (s_busy !== 1'b1) $display("FAIL rst_first_busy: got %b want 1", s_busy); else n_pass++;
        n_chk++; if (s_gid !== 2'd0) $display("FAIL rst_first_gid: got %0d want 0", s_gid); else n_pass++;
        n_chk++; if (s_winc !== 1'b1) $display("FAIL rst_first_winc: got %b want 1", s_winc); else n_pass++;
        n_chk++; if (s_ready !== 4'b0001) $display("FAIL rst_first_ready: got %b want 0001", s_ready); else n_pass++;
    endtask

    task automatic test_packets();
        logic [19:0]   wpat;
        int            own [5];
        int            pk  [5];
        logic [DW-1:0] exp_w;
        own = '{0, 1, 2, 3, 0};
        pk  = '{0, 0, 0, 0, 1};
        for (int i = 0; i < N; i++) len[i] = 3;
        npkt = '{2, 1, 1, 1};
        do_reset(4'b1111);
        wpat = '0;
        for (int t = 0; t < 20; t++) begin
            tick4();
            wpat[t] = s_winc;
        end
        n_chk++; if (wpat !== 20'hEEEEE) $display("FAIL pkt_winc_pattern: got %h want eeeee", wpat); else n_pass++;
        n_chk++; if (log_q.size() !== 15) $display("FAIL pkt_log_size: got %0d want 15", log_q.size()); else n_pass++;
        for (int k = 0; k < 15 && k < log_q.size(); k++) begin
            exp_w = DW'(own[k/3]*64 + pk[k/3]*8 + k%3);
            n_chk++; if (log_q[k] !== exp_w) $display("FAIL pkt_word%0d: got %0h want %0h", k, log_q[k], exp_w); else n_pass++;
        end
        tick4();
        n_chk++; if ({s_busy, s_winc} !== 2'b00) $display("FAIL pkt_drained: got busy/winc %b want 00", {s_busy, s_winc}); else n_pass++;
    endtask

    task automatic test_wfull();
        for (int i = 0; i < N; i++) begin
            len[i]  = 6;
            npkt[i] = 1;
        end
        do_reset(4'b0010);
        tick4();
        tick4();
        tick4();
        n_chk++; if (s_ready !== 4'b0010) $display("FAIL full_ready_pre: got %b want 0010", s_ready); else n_pass++;
        wfull_drv = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick4();
            n_chk++; if ({s_winc, s_ready} !== 5'b0) $display("FAIL full_stall%0d: got winc/ready %b want 00000", t, {s_winc, s_ready}); else n_pass++;
            n_chk++; if ({s_busy, s_gid} !== 3'b101) $display("FAIL full_grant%0d: got busy/gid %b want 101", t, {s_busy, s_gid}); else n_pass++;
        end
        wfull_drv = 1'b0;
        tick4();
        n_chk++; if ({s_winc, s_wdata} !== {1'b1, 8'd66}) $display("FAIL full_resume: got winc %b data %0d want 1 66", s_winc, s_wdata); else n_pass++;
        repeat (3) tick4();
        n_chk++; if (log_q.size() !== 6) $display("FAIL full_log_size: got %0d want 6", log_q.size()); else n_pass++;
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            n_chk++; if (log_q[k] !== DW'(64 + k)) $display("FAIL full_word%0d: got %0d want %0d", k, log_q[k], 64 + k); else n_pass++;
        end
    endtask

    task automatic test_owner_stall();
        logic [DW-1:0] exp_log [5];
        exp_log = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd64};
        len  = '{4, 1, 1, 1};
        npkt = '{1, 1, 1, 0};
        do_reset(4'b0111);
        tick4();
        tick4();
        tick4();
        en[0] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick4();
            n_chk++; if ({s_gid, s_winc, s_ready} !== {2'd0, 1'b0, 4'b0001}) $display("FAIL hold%0d: got gid/winc/ready %b want 0000001", t, {s_gid, s_winc, s_ready}); else n_pass++;
        end
        en[0] = 1'b1;
        tick4();
        tick4();
        n_chk++; if (s_ready !== 4'b0001) $display("FAIL hold_last_ready: got %b want 0001", s_ready); else n_pass++;
        tick4();
        n_chk++; if (s_busy !== 1'b0) $display("FAIL hold_rearb: got busy %b want 0", s_busy); else n_pass++;
        tick4();
        n_chk++; if ({s_gid, s_winc, s_wdata} !== {2'd1, 1'b1, 8'd64}) $display("FAIL hold_next_owner: got gid %0d winc %b data %0d want 1 1 64", s_gid, s_winc, s_wdata); else n_pass++;
        n_chk++; if (log_q.size() !== 5) $display("FAIL hold_log_size: got %0d want 5", log_q.size()); else n_pass++;
        for (int k = 0; k < 5 && k < log_q.size(); k++) begin
            n_chk++; if (log_q[k] !== exp_log[k]) $display("FAIL hold_word%0d: got %0d want %0d", k, log_q[k], exp_log[k]); else n_pass++;
        end
    endtask

    task automatic test_single_word();
        logic [5:0] wpat;
        for (int i = 0; i < N; i++) len[i] = 1;
        npkt = '{0, 0, 3, 0};
        do_reset(4'b0100);
        wpat = '0;
        for (int t = 0; t < 6; t++) begin
            tick4();
            wpat[t] = s_winc;
            if (t % 2 == 1) begin
                n_chk++; if (s_gid !== 2'd2) $display("FAIL single_gid%0d: got %0d want 2", t, s_gid); else n_pass++;
                n_chk++; if (dut4.r_rr_ptr !== 2'd3) $display("FAIL single_rrptr%0d: got %0d want 3", t, dut4.r_rr_ptr); else n_pass++;
            end
        end
        n_chk++; if (wpat !== 6'b101010) $display("FAIL single_winc_pattern: got %b want 101010", wpat); else n_pass++;
    endtask

    task automatic test_num_req3();
        logic [7:0] wpat;
        logic       saw3;
        int         exp_gid  [4];
        int         exp_data [4];
        exp_gid  = '{0, 1, 2, 0};
        exp_data = '{10, 11, 12, 10};
        for (int i = 0; i < N; i++) npkt[i] = 0;
        do_reset(4'b0000);
        b3.req_valid = 3'b111;
        b3.req_last  = 3'b111;
        b3.req_data  = {8'd12, 8'd11, 8'd10};
        b3.wfull     = 1'b0;
        wpat = '0;
        saw3 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            #2;
            wpat[t] = b3.winc;
            if (b3.grant_id == 2'd3) saw3 = 1'b1;
            if (t % 2 == 1) begin
                n_chk++; if (b3.grant_id !== 2'(exp_gid[t/2])) $display("FAIL n3_gid%0d: got %0d want %0d", t, b3.grant_id, exp_gid[t/2]); else n_pass++;
                n_chk++; if (b3.wdata !== 8'(exp_data[t/2])) $display("FAIL n3_data%0d: got %0d want %0d", t, b3.wdata, exp_data[t/2]); else n_pass++;
            end
            @(posedge wclk);
            #1;
        end
        n_chk++; if (wpat !== 8'b10101010) $display("FAIL n3_winc_pattern: got %b want 10101010", wpat); else n_pass++;
        n_chk++; if (saw3 !== 1'b0) $display("FAIL n3_gid_range: got grant_id 3 seen=%b want 0", saw3); else n_pass++;
        idle3();
    endtask

    initial begin
        wrst_n    = 1'b0;
        en        = '0;
        wfull_drv = 1'b0;
        b4.req_valid = '0;
        b4.req_last  = '0;
        b4.req_data  = '0;
        b4.wfull     = 1'b0;
        idle3();
        test_reset();
        test_packets();
        test_wfull();
        test_owner_stall();
        test_single_word();
        test_num_req3();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
